// File: rtl/ahb_lite_pkg.sv
// Shared constants and types for the two-client AHB-Lite arbiter.
package ahb_lite_pkg;

    localparam int unsigned HTRANS_W    = 2;
    localparam int unsigned NUM_CLIENTS = 2;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

    // Index of the client that owns a bus phase slot.
    typedef logic owner_t;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational two-way round-robin pick: the client other than lp wins a tie.
module ahb_rr_pick
    import ahb_lite_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] eligible,
    input  owner_t                 lp,
    output logic                   grant_valid,
    output owner_t                 grant_idx
);

    // Single eligible client wins outright; on a tie the one not granted last wins.
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        case (eligible)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~lp;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Shares one AHB-Lite master port between two REQ/ACK clients, pipelining
// one client's address phase over the other's data phase.
module ahb_lite_arbiter
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                M0_REQ,
    input  logic                M0_WRITE,
    input  logic [ADDR_W-1:0]   M0_ADDR,
    input  logic [DATA_W-1:0]   M0_WDATA,
    output logic                M0_ACK,
    output logic [DATA_W-1:0]   M0_RDATA,
    input  logic                M1_REQ,
    input  logic                M1_WRITE,
    input  logic [ADDR_W-1:0]   M1_ADDR,
    input  logic [DATA_W-1:0]   M1_WDATA,
    output logic                M1_ACK,
    output logic [DATA_W-1:0]   M1_RDATA,
    output logic [ADDR_W-1:0]   HADDR,
    output logic                HWRITE,
    output logic [HTRANS_W-1:0] HTRANS,
    output logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADY,
    input  logic [DATA_W-1:0]   HRDATA
);

    logic                   aph_valid;
    owner_t                 aph_owner;
    logic [ADDR_W-1:0]      aph_addr;
    logic                   aph_write;
    logic [DATA_W-1:0]      aph_wdata;
    logic [HTRANS_W-1:0]    htrans_q;

    logic                   dph_valid;
    owner_t                 dph_owner;
    logic                   dph_write;
    logic [DATA_W-1:0]      dph_wdata;

    owner_t                 lp;
    logic [NUM_CLIENTS-1:0] ack_q;
    logic [DATA_W-1:0]      rdata_q [NUM_CLIENTS];

    logic [NUM_CLIENTS-1:0] eligible;
    logic                   grant_valid;
    owner_t                 grant_idx;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_write;
    logic [DATA_W-1:0]      sel_wdata;

    // A client may be granted only with no transfer in flight and outside its ACK cycle.
    always_comb begin
        eligible[0] = M0_REQ && !(aph_valid && aph_owner == 1'b0)
                             && !(dph_valid && dph_owner == 1'b0) && !ack_q[0];
        eligible[1] = M1_REQ && !(aph_valid && aph_owner == 1'b1)
                             && !(dph_valid && dph_owner == 1'b1) && !ack_q[1];
    end

    ahb_rr_pick u_pick (
        .eligible    (eligible),
        .lp          (lp),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Request fields of the grant winner.
    always_comb begin
        sel_addr  = grant_idx ? M1_ADDR  : M0_ADDR;
        sel_write = grant_idx ? M1_WRITE : M0_WRITE;
        sel_wdata = grant_idx ? M1_WDATA : M0_WDATA;
    end

    // Pipeline advance on HREADY: retire data phase, shift address phase, load new grant.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            aph_valid  <= 1'b0;
            aph_owner  <= 1'b0;
            aph_addr   <= '0;
            aph_write  <= 1'b0;
            aph_wdata  <= '0;
            htrans_q   <= HTRANS_IDLE;
            dph_valid  <= 1'b0;
            dph_owner  <= 1'b0;
            dph_write  <= 1'b0;
            dph_wdata  <= '0;
            lp         <= 1'b1;
            ack_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else if (HREADY) begin
            ack_q <= '0;
            if (dph_valid) begin
                ack_q[dph_owner] <= 1'b1;
                if (!dph_write) begin
                    rdata_q[dph_owner] <= HRDATA;
                end
            end
            dph_valid <= aph_valid;
            dph_owner <= aph_owner;
            dph_write <= aph_write;
            dph_wdata <= aph_wdata;
            aph_valid <= grant_valid;
            htrans_q  <= grant_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (grant_valid) begin
                aph_owner <= grant_idx;
                aph_addr  <= sel_addr;
                aph_write <= sel_write;
                aph_wdata <= sel_wdata;
                lp        <= grant_idx;
            end
        end else begin
            ack_q <= '0;
        end
    end

    assign HADDR    = aph_addr;
    assign HWRITE   = aph_write;
    assign HTRANS   = htrans_q;
    assign HWDATA   = dph_wdata;
    assign M0_ACK   = ack_q[0];
    assign M1_ACK   = ack_q[1];
    assign M0_RDATA = rdata_q[0];
    assign M1_RDATA = rdata_q[1];

endmodule

// File: doc/ahb_lite_arbiter.md
# ahb_lite_arbiter

Two-requester controller that shares a single AHB-Lite master port between two local clients (M0, M1). Each client issues single-word read/write requests over a REQ/ACK handshake. The block arbitrates round-robin and drives the AHB-Lite address and data phases, pipelining one client's address phase over the other's data phase. It sits between the client logic and the AHB-Lite slave/decoder, replacing a direct per-client bus master.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports (x = 0, 1):
- HCLK  in  1  bus clock; all logic on rising edge
- HRESET  in  1  reset; synchronous, active-high
- Mx_REQ  in  1  request; held high with Mx_WRITE/ADDR/WDATA stable until Mx_ACK
- Mx_WRITE  in  1  1 = write, 0 = read
- Mx_ADDR  in  ADDR_W  transfer address
- Mx_WDATA  in  DATA_W  write data
- Mx_ACK  out  1  one-cycle completion pulse, registered
- Mx_RDATA  out  DATA_W  read data, valid with Mx_ACK, held until this client's next completion
- HADDR  out  ADDR_W  AHB address
- HWRITE  out  1  AHB direction
- HTRANS  out  2  IDLE = 2'b00, NONSEQ = 2'b10
- HWDATA  out  DATA_W  AHB write data, driven during the data phase
- HREADY  in  1  slave ready; extends the current data phase when low
- HRDATA  in  DATA_W  slave read data

## Operation
- **Internal registers**
  - Address-phase slot: aph_valid, aph_owner, aph_addr, aph_write, aph_wdata.
  - Data-phase slot: dph_valid, dph_owner, dph_write, dph_wdata.
  - lp: last-granted pointer.
- **Outputs**
  - HTRANS = NONSEQ when aph_valid, else IDLE.
  - HADDR and HWRITE come from the address-phase slot.
  - HWDATA = dph_wdata.
  - All bus outputs are registered.
- **Eligibility:** a client is eligible when Mx_REQ = 1 and it owns neither slot and it is not in its Mx_ACK cycle. One outstanding transfer per client. REQ sampled during the ACK cycle is ignored.
- **Advance:** occurs only on an edge where HREADY = 1.
  - If dph_valid: the data phase completes. For a read, HRDATA is captured into Mowner_RDATA. Mowner_ACK = 1 in the next cycle, for reads and writes.
  - The data-phase slot loads from the address-phase slot.
  - The address-phase slot loads the grant winner: ADDR/WRITE/WDATA are captured, aph_valid = 1, lp = winner. If nothing is eligible, aph_valid = 0.
- **Round-robin:**
  - If one client is eligible, it wins.
  - If both are eligible, the client ≠ lp wins.
  - lp resets to 1, so M0 wins the first contention.
- **Stall (HREADY = 0 at an edge):** both slots, HADDR, HWRITE, HTRANS, HWDATA and lp hold. No grant, no ACK.
- **Reset:**
  - Values: aph_valid = dph_valid = 0, HTRANS = IDLE, HADDR = 0, HWRITE = 0, HWDATA = 0, M0/M1_ACK = 0, M0/M1_RDATA = 0, lp = 1.
  - Reset mid-transfer abandons any in-flight transfer; no ACK is ever issued for it.

## Timing
- REQ sampled at edge N (HREADY = 1) gives:
  - address phase (NONSEQ) in cycle N..N+1;
  - data phase in cycle N+1..N+2;
  - completion at edge N+2;
  - ACK/RDATA in cycle N+2..N+3.
- Each cycle HREADY is low at a data-phase edge adds exactly one cycle.
- Back-to-back requests from one client: next REQ is sampled no earlier than the edge ending its ACK cycle.
- Both clients requesting continuously: address phases alternate M0, M1, M0, M1…; M1's address phase overlaps M0's data phase.
- A write's HWDATA equals the WDATA captured at grant, not the live Mx_WDATA.

## Structure
- Package ahb_lite_pkg:
  - HTRANS_IDLE / HTRANS_NONSEQ constants;
  - owner-index type.
- Sub-module ahb_rr_pick: combinational 2-way round-robin pick.
  - Inputs: eligible[1:0], lp.
  - Outputs: grant_valid, grant_idx.
- Top level holds both phase slots, RDATA/ACK registers and the bus output registers.

## Test plan
- **Single read, no waits:** M0_REQ = 1, ADDR = 0x100, WRITE = 0; slave returns 0xDEADBEEF with HREADY = 1.
  - HTRANS = NONSEQ, HADDR = 0x100 one cycle.
  - M0_ACK pulses 2 cycles later with M0_RDATA = 0xDEADBEEF.
- **Write with 2 wait states:** M1 writes 0xA5A5A5A5 to 0x200; HREADY low 2 cycles in the data phase.
  - HWDATA = 0xA5A5A5A5 held throughout.
  - M1_ACK is 2 cycles later than the no-wait case.
  - HTRANS = IDLE during the stall (nothing pending).
- **Contention:** M0 and M1 both raise REQ in the same cycle, held continuously.
  - Grant order M0, M1, M0, M1.
  - M1's address phase coincides with M0's data phase.
- **Stall with pending address:** HREADY low while M1's address phase (0x300) is pending.
  - HADDR = 0x300 and HTRANS = NONSEQ held unchanged.
  - No new grant.
- **Reset mid-operation:** HRESET = 1 during M0's data phase.
  - All outputs take reset values next cycle.
  - M0_ACK never asserts.
  - Post-reset M0 read to 0x104 completes normally.
